// File: rtl/program_loader.sv
// program_loader: receives a length-prefixed little-endian word stream from a UART rx FIFO, writes it to instruction memory and acknowledges over tx
module program_loader #(
    parameter int          ADDR_W   = 12,
    parameter logic [7:0]  ACK_BYTE = 8'hAA
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_empty,
    output logic              rx_rd_en,
    output logic [7:0]        tx_data,
    input  logic              tx_full,
    output logic              tx_wr_en,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {IDLE, LEN, DATA, ACK, DONE, ERR} state_t;
    state_t            state;
    logic [1:0]        byte_cnt;
    logic [ADDR_W:0]   word_cnt;
    logic [ADDR_W:0]   n_words;
    logic [31:0]       word_asm;
    logic [31:0]       asm_nx;
    logic [ADDR_W:0]   word_nx;
    logic              last_byte;
    logic              too_big;
    assign rx_rd_en  = (state == LEN || state == DATA) && !rx_empty;
    assign last_byte = rx_rd_en && byte_cnt == 2'd3;
    assign word_nx   = word_cnt + {{ADDR_W{1'b0}}, 1'b1};
    assign too_big   = {1'b0, asm_nx} > (33'd1 << ADDR_W);
    assign busy      = state == LEN || state == DATA || state == ACK;
    assign done      = state == DONE;
    assign err       = state == ERR;
    always_comb begin
        asm_nx = word_asm;
        asm_nx[{byte_cnt, 3'b000} +: 8] = rx_data;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            word_cnt   <= '0;
            n_words    <= '0;
            word_asm   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            tx_wr_en   <= 1'b0;
            tx_data    <= '0;
        end else begin
            imem_we  <= 1'b0;
            tx_wr_en <= 1'b0;
            if (rx_rd_en) begin
                word_asm <= asm_nx;
                byte_cnt <= byte_cnt + 2'd1;
            end
            case (state)
                IDLE, DONE, ERR: if (start) begin
                    state    <= LEN;
                    byte_cnt <= '0;
                    word_cnt <= '0;
                end
                LEN: if (last_byte) begin
                    state   <= asm_nx == 32'd0 ? ACK : too_big ? ERR : DATA;
                    n_words <= asm_nx[ADDR_W:0];
                end
                DATA: if (last_byte) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= word_cnt[ADDR_W-1:0];
                    imem_wdata <= asm_nx;
                    word_cnt   <= word_nx;
                    state      <= word_nx == n_words ? ACK : DATA;
                end
                ACK: if (!tx_full) begin
                    tx_wr_en <= 1'b1;
                    tx_data  <= ACK_BYTE;
                    state    <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized self-checking bench for program_loader against a session-level reference model
module tb_program_loader;
    localparam int AW = 4;
    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_empty = 1'b1;
    logic          tx_full = 1'b0;
    logic          rx_rd_en, tx_wr_en, imem_we, busy, done, err;
    logic [7:0]    tx_data;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    byte unsigned  rx_q[$];
    logic [35:0]   got[$];
    int            gap = 0, gap_left = 0, pops = 0, tx_cnt = 0, viol = 0;
    int            n_cmp = 0, n_err = 0;
    logic          pend_pop = 1'b0;
    logic [7:0]    tx_last = 8'h00;
    always #5 clk = ~clk;
    program_loader #(.ADDR_W(AW), .ACK_BYTE(8'hAA)) dut (
        .clk(clk), .rstn(rstn), .start(start), .rx_data(rx_data), .rx_empty(rx_empty),
        .rx_rd_en(rx_rd_en), .tx_data(tx_data), .tx_full(tx_full), .tx_wr_en(tx_wr_en),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err)
    );
    always @(negedge clk) begin
        pend_pop = rx_rd_en;
        if (rx_rd_en && rx_empty) viol++;
        if (imem_we) got.push_back({imem_addr, imem_wdata});
        if (tx_wr_en) begin
            tx_cnt++;
            tx_last = tx_data;
        end
    end
    always @(posedge clk) begin
        #1;
        if (pend_pop && rstn) begin
            void'(rx_q.pop_front());
            pops++;
            gap_left = gap;
        end else if (gap_left > 0) gap_left--;
        rx_empty = (rx_q.size() == 0) || (gap_left > 0);
        rx_data  = rx_q.size() != 0 ? rx_q[0] : 8'h00;
    end
    task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        n_cmp++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask
    task automatic check_reset_outputs(input string tag);
        check({tag, "_imem_we"}, imem_we, 0);
        check({tag, "_imem_addr"}, imem_addr, 0);
        check({tag, "_imem_wdata"}, imem_wdata, 0);
        check({tag, "_tx_wr_en"}, tx_wr_en, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_rx_rd_en"}, rx_rd_en, 0);
    endtask
    task automatic push32(input logic [31:0] v);
        for (int i = 0; i < 4; i++) rx_q.push_back(v[8*i +: 8]);
    endtask
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask
    task automatic run_session(input logic [31:0] n, input int gap_c, input int full_c, input bit fixed);
        logic [31:0] w[$];
        bit ok;
        int nw, g0, t0, v0, t;
        ok = n <= 32'd16;
        nw = ok ? int'(n) : 0;
        for (int k = 0; k < nw; k++) w.push_back(fixed ? (k == 0 ? 32'h13 : 32'h6F) : $urandom());
        g0 = got.size();
        t0 = tx_cnt;
        v0 = viol;
        gap = gap_c;
        tx_full = full_c > 0;
        push32(n);
        foreach (w[k]) push32(w[k]);
        pulse_start();
        if (full_c > 0) begin
            t = 0;
            while (got.size() < g0 + nw && t < 3000) begin
                @(negedge clk);
                t++;
            end
            repeat (full_c) @(negedge clk);
            check("tx_hold", tx_cnt - t0, 0);
            check("busy_ack", busy, 1);
            tx_full = 1'b0;
        end
        t = 0;
        while (!(done || err) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("timeout", t < 3000, 1);
        repeat (2) @(negedge clk);
        check("n_writes", got.size() - g0, nw);
        for (int k = 0; k < nw && k + g0 < got.size(); k++) begin
            logic [AW-1:0] a;
            a = k[AW-1:0];
            check("write", got[g0 + k], {a, w[k]});
        end
        check("tx_cnt", tx_cnt - t0, ok);
        if (tx_cnt != t0) check("tx_data", tx_last, 8'hAA);
        check("done", done, ok);
        check("err", err, !ok);
        check("busy_end", busy, 0);
        check("rd_while_empty", viol - v0, 0);
        check("rx_drained", rx_q.size(), 0);
    endtask
    initial begin
        int p0, t, g1;
        logic [31:0] n;
        #2 rstn = 1'b0;
        #1 check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        run_session(2, 0, 0, 1);
        run_session(2, 5, 0, 1);
        run_session(17, 0, 0, 0);
        run_session(16, 0, 0, 0);
        run_session(0, 0, 0, 0);
        run_session(3, 0, 10, 0);
        gap = 0;
        p0 = pops;
        push32(2);
        push32(32'hDEADBEEF);
        push32(32'h12345678);
        pulse_start();
        t = 0;
        while (pops < p0 + 10 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("mid_timeout", t < 500, 1);
        g1 = got.size();
        #1 rstn = 1'b0;
        #1 check_reset_outputs("mid");
        @(negedge clk);
        rx_q.delete();
        p0 = pops;
        @(negedge clk) rstn = 1'b1;
        push32(32'h00000001);
        repeat (6) @(negedge clk);
        check("post_rst_rd_en", rx_rd_en, 0);
        check("post_rst_pops", pops - p0, 0);
        check("post_rst_we", got.size() - g1, 0);
        check("post_rst_busy", busy, 0);
        rx_q.delete();
        repeat (2) @(negedge clk);
        run_session(2, 0, 0, 1);
        for (int i = 0; i < 12; i++) begin
            int r;
            r = $urandom_range(0, 9);
            n = r == 0 ? 32'd0 : r == 1 ? ($urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'(17 + $urandom_range(0, 100))) : 32'($urandom_range(1, 16));
            run_session(n, $urandom_range(0, 2), (n != 0 && n <= 16 && $urandom_range(0, 1) == 1) ? 3 : 0, 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_W, default 12, sets the instruction-memory word-address width (capacity 2^ADDR_W words).
REQ-002 Parameter ACK_BYTE, default 8'hAA, is the byte sent to the host after a successful load.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  one-cycle request to begin a load session.
REQ-006 rx_data  input  8  head byte of UART receive FIFO; valid whenever rx_empty=0.
REQ-007 rx_empty  input  1  receive FIFO empty flag.
REQ-008 rx_rd_en  output  1  pops head byte of receive FIFO in the cycle asserted.
REQ-009 tx_data  output  8  byte to push into UART transmit FIFO.
REQ-010 tx_full  input  1  transmit FIFO full flag.
REQ-011 tx_wr_en  output  1  pushes tx_data into transmit FIFO in the cycle asserted.
REQ-012 imem_we  output  1  instruction-memory write strobe.
REQ-013 imem_addr  output  ADDR_W  word address for the write.
REQ-014 imem_wdata  output  32  word written.
REQ-015 busy  output  1  high while a session is in progress (LEN, DATA, ACK).
REQ-016 done  output  1  high after a successful load, until the next start or reset.
REQ-017 err  output  1  high after a rejected length, until the next start or reset.

Function
REQ-018 The FSM SHALL have the states IDLE, LEN, DATA, ACK, DONE and ERR.
REQ-019 Host protocol SHALL be: 32-bit word count N, little-endian, then N words of 4 bytes each, little-endian.
REQ-020 IDLE, DONE or ERR with start=1 -> LEN; clears byte_cnt, word_cnt, done and err.
REQ-021 start SHALL be ignored in LEN, DATA and ACK.
REQ-022 rx_rd_en SHALL equal (state is LEN or DATA) AND NOT rx_empty, combinationally; every cycle with rx_rd_en=1 consumes rx_data.
REQ-023 A 2-bit byte_cnt SHALL place each consumed byte at bits [8*byte_cnt+7 : 8*byte_cnt] of a 32-bit assembly register, then wrap 3->0.
REQ-024 LEN, on the 4th byte: N=0 -> ACK; N>2^ADDR_W -> ERR; otherwise latch N and go to DATA.
REQ-025 DATA, on the 4th byte of word k: in the next cycle imem_we=1 for exactly one cycle, with imem_addr=k[ADDR_W-1:0] and imem_wdata=the assembled word.
REQ-026 DATA: after word N-1 is consumed, go to ACK in the same cycle its imem_we register is loaded; no further bytes are popped.
REQ-027 word_cnt SHALL be ADDR_W+1 bits wide, so N=2^ADDR_W is accepted and ends at address 2^ADDR_W-1.
REQ-028 ACK: when tx_full=0, assert tx_wr_en for exactly one cycle with tx_data=ACK_BYTE, then go to DONE; while tx_full=1, wait with tx_wr_en=0.
REQ-029 DONE SHALL hold done=1; ERR SHALL hold err=1; neither state pops rx.
REQ-030 rx_empty=1 mid-word SHALL stall assembly with no byte loss and no timeout.
REQ-031 imem_addr and imem_wdata SHALL hold their last values when imem_we=0.

Reset
REQ-032 When rstn=0, asynchronously: state=IDLE, byte_cnt=0, word_cnt=0, assembly register=0, imem_we=0, imem_addr=0, imem_wdata=0, tx_wr_en=0, tx_data=0, busy=0, done=0, err=0.
REQ-033 Reset mid-session SHALL abandon the session; no further imem_we or tx_wr_en until a new start.
REQ-034 With state=IDLE, rx_rd_en=0 regardless of rx_empty.

Verification
REQ-035 start, bytes 02 00 00 00 | 13 00 00 00 | 6F 00 00 00 with no gaps -> two imem_we pulses: (addr 0, 32'h00000013) and (addr 1, 32'h0000006F); then one tx_wr_en with tx_data=8'hAA; done=1, busy=0.
REQ-036 Same stream with rx_empty=1 for 5 cycles between each byte -> identical writes and ack; rx_rd_en never asserted while rx_empty=1.
REQ-037 ADDR_W=4, N=17 -> err=1, no imem_we, no tx_wr_en; a following start with N=16 -> 16 writes at addresses 0..15, then the ack.
REQ-038 N=0 -> no imem_we; ack byte 8'hAA sent; done=1.
REQ-039 tx_full=1 held 10 cycles in ACK -> tx_wr_en stays 0, then a single pulse once tx_full=0.
REQ-040 rstn=0 after 2 bytes of word 1 -> all outputs return to their reset values immediately; rx_rd_en=0 until the next start; a new start performs a clean full load.
